mem_arbiter: RTL and testbench

- Arbitrates the pipeline's instruction-fetch port and load/store-unit port onto one shared single-port memory bus, with one transaction outstanding at a time.
- Generates the fetch-side and data-side stall requests consumed by the hazard unit.
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Fetch responses cancelled by a branch flush are dropped.

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory bus between the instruction-fetch port and
//   the load/store port. Only one bus transaction is outstanding at a time.
//   Data accesses win arbitration unless fetch has been passed over
//   STARVE_LIMIT times in a row. A fetch cancelled by a branch flush still
//   completes on the bus, but its response is dropped.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     if_req/if_addr/if_flush  fetch request, address, branch cancel
//     if_rdata/if_valid        fetched instruction and one-cycle strobe
//     if_stall                 fetch waiting (to hazard unit)
//     dm_req/dm_wr/dm_mask/dm_addr/dm_wdata  data request and command
//     dm_rdata/dm_valid        load data and one-cycle strobe
//     dm_stall                 data access waiting (to hazard unit)
//     mem_req/mem_wr/mem_mask/mem_addr/mem_wdata  bus command
//     mem_gnt                  bus accepted the command this cycle
//     mem_rvalid/mem_rdata     bus response (read data or write ack)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transaction; arbitrate and latch the winner's command
//   REQ   | mem_req high with the latched command, waiting for mem_gnt
//   RESP  | command accepted, waiting for mem_rvalid
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,

  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [3:0]        dm_mask,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_mask,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              owner_fetch, owner_fetch_nxt;
  logic              drop, drop_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;

  logic              cmd_wr, cmd_wr_nxt;
  logic [3:0]        cmd_mask, cmd_mask_nxt;
  logic [DATA_W-1:0] cmd_addr, cmd_addr_nxt;
  logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;

  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_valid_q, dm_valid_q;

  logic fetch_elig, data_elig;
  logic grant_data, grant_fetch;
  logic drop_now, rsp_done;

  // A requester is never eligible in its own valid cycle, so a held level
  // request is not re-issued before the requester has seen its response.
  assign fetch_elig = if_req & ~if_flush & ~if_valid_q;
  assign data_elig  = dm_req & ~dm_valid_q;

  // With STARVE_LIMIT = 0 the compare is never true, so fetch wins ties.
  assign grant_data  = data_elig & (~fetch_elig | (starve_cnt < CNT_MAX));
  assign grant_fetch = fetch_elig & ~grant_data;

  // A flush in the response cycle itself must also suppress the strobe.
  assign drop_now = drop | (owner_fetch & if_flush);
  assign rsp_done = (state == RESP) & mem_rvalid;

  always_comb begin
    state_nxt       = state;
    owner_fetch_nxt = owner_fetch;
    drop_nxt        = drop;
    starve_cnt_nxt  = starve_cnt;
    cmd_wr_nxt      = cmd_wr;
    cmd_mask_nxt    = cmd_mask;
    cmd_addr_nxt    = cmd_addr;
    cmd_wdata_nxt   = cmd_wdata;

    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (grant_data) begin
          state_nxt       = REQ;
          owner_fetch_nxt = 1'b0;
          cmd_wr_nxt      = dm_wr;
          cmd_mask_nxt    = dm_mask;
          cmd_addr_nxt    = dm_addr;
          cmd_wdata_nxt   = dm_wdata;
          if (fetch_elig) begin
            if (starve_cnt != CNT_MAX) begin
              starve_cnt_nxt = starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt_nxt = '0;
          end
        end else if (grant_fetch) begin
          state_nxt       = REQ;
          owner_fetch_nxt = 1'b1;
          cmd_wr_nxt      = 1'b0;
          cmd_mask_nxt    = 4'hF;
          cmd_addr_nxt    = if_addr;
          cmd_wdata_nxt   = '0;
          starve_cnt_nxt  = '0;
        end
      end

      REQ: begin
        drop_nxt = drop_now;
        // Any rvalid here (including one coincident with gnt) is ignored.
        if (mem_gnt) begin
          state_nxt = RESP;
        end
      end

      RESP: begin
        drop_nxt = drop_now;
        if (mem_rvalid) begin
          state_nxt = IDLE;
          drop_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_fetch <= 1'b0;
      drop        <= 1'b0;
      starve_cnt  <= '0;
      cmd_wr      <= 1'b0;
      cmd_mask    <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      owner_fetch <= owner_fetch_nxt;
      drop        <= drop_nxt;
      starve_cnt  <= starve_cnt_nxt;
      cmd_wr      <= cmd_wr_nxt;
      cmd_mask    <= cmd_mask_nxt;
      cmd_addr    <= cmd_addr_nxt;
      cmd_wdata   <= cmd_wdata_nxt;
    end
  end

  // Response capture: rdata registers hold between responses; a write ack
  // strobes dm_valid without touching dm_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      if_valid_q <= rsp_done & owner_fetch & ~drop_now;
      dm_valid_q <= rsp_done & ~owner_fetch;
      if (rsp_done & owner_fetch & ~drop_now) begin
        if_rdata_q <= mem_rdata;
      end
      if (rsp_done & ~owner_fetch & ~cmd_wr) begin
        dm_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_wr    = cmd_wr;
  assign mem_mask  = cmd_mask;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;

  assign if_stall  = if_req & ~if_valid_q & ~if_flush;
  assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed lone-fetch latency check, then randomized fetch/data/bus traffic
//   compared cycle by cycle against a transaction-level reference model,
//   with one reset asserted in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_valid, dm_stall;
  logic [3:0]  dm_mask;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_mask(dm_mask), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by flags.
  bit          m_busy, m_gnt, m_fetch, m_drop, m_ifv, m_dmv;
  int          m_cnt;
  logic [31:0] m_ifr, m_dmr, m_addr, m_wdata;
  logic        m_wr;
  logic [3:0]  m_mask;
  bit          f_act, d_act;
  int          rv_wait;

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_fetch = 0; m_drop = 0; m_ifv = 0; m_dmv = 0;
    m_cnt = 0; m_ifr = '0; m_dmr = '0; m_addr = '0; m_wdata = '0;
    m_wr = 0; m_mask = '0; f_act = 0; d_act = 0; rv_wait = 0;
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_wr = 0; dm_mask = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit fe, de, nifv, ndmv;
    nifv = 0; ndmv = 0;
    if (!m_busy) begin
      fe = if_req && !if_flush && !m_ifv;
      de = dm_req && !m_dmv;
      if (de && (!fe || m_cnt < LIMIT)) begin
        m_busy = 1; m_gnt = 0; m_fetch = 0;
        m_wr = dm_wr; m_mask = dm_mask; m_addr = dm_addr; m_wdata = dm_wdata;
        m_cnt = fe ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
      end else if (fe) begin
        m_busy = 1; m_gnt = 0; m_fetch = 1;
        m_wr = 0; m_mask = 4'hF; m_addr = if_addr; m_wdata = '0;
        m_cnt = 0;
      end
    end else begin
      if (m_fetch && if_flush) m_drop = 1;
      if (!m_gnt) begin
        if (mem_gnt) begin
          m_gnt = 1;
          rv_wait = $urandom_range(0, 2);
        end
      end else if (mem_rvalid) begin
        m_busy = 0;
        if (m_fetch) begin
          if (!m_drop) begin
            nifv = 1;
            m_ifr = mem_rdata;
          end
        end else begin
          ndmv = 1;
          if (!m_wr) m_dmr = mem_rdata;
        end
        m_drop = 0;
      end
    end
    m_ifv = nifv;
    m_dmv = ndmv;
  endtask

  task automatic new_dm_cmd();
    dm_wr    = $urandom_range(0, 1);
    dm_mask  = 4'($urandom_range(1, 15));
    dm_addr  = $urandom & 32'hFFFF_FFFC;
    dm_wdata = $urandom;
  endtask

  bit done_rst;

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();
    done_rst = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_dm_valid", dm_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b1;

    // Lone fetch with a zero-wait bus: valid three cycles after the request.
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    #1 check("lone_stall_c0", if_stall, 1'b1);
    check("lone_req_c0", mem_req, 1'b0);
    @(negedge clk);
    check("lone_req_c1", mem_req, 1'b1);
    check("lone_addr_c1", mem_addr, 32'h100);
    check("lone_mask_c1", mem_mask, 4'hF);
    check("lone_stall_c1", if_stall, 1'b1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    check("lone_req_c2", mem_req, 1'b0);
    check("lone_valid_c2", if_valid, 1'b0);
    check("lone_stall_c2", if_stall, 1'b1);
    mem_rvalid = 1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    check("lone_valid_c3", if_valid, 1'b1);
    check("lone_rdata_c3", if_rdata, 32'h0050_0093);
    check("lone_stall_c3", if_stall, 1'b0);
    if_req = 0;
    @(negedge clk);
    check("lone_valid_c4", if_valid, 1'b0);
    check("lone_rdata_hold", if_rdata, 32'h0050_0093);
    model_reset();
    m_ifr = 32'h0050_0093;

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check("mem_req", mem_req, m_busy && !m_gnt);
      if (m_busy && !m_gnt) begin
        check("mem_wr", mem_wr, m_wr);
        check("mem_mask", mem_mask, m_mask);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
      end
      check("if_valid", if_valid, m_ifv);
      check("dm_valid", dm_valid, m_dmv);
      check("if_rdata", if_rdata, m_ifr);
      check("dm_rdata", dm_rdata, m_dmr);

      if (!done_rst && cyc >= 2000 && m_busy && m_gnt) begin
        done_rst = 1;
        #2 rst = 1'b0;
        #1 check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_if_valid", if_valid, 1'b0);
        check("midrst_dm_valid", dm_valid, 1'b0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_dm_rdata", dm_rdata, 32'h0);
        check("midrst_if_rdata", if_rdata, 32'h0);
        drive_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        continue;
      end

      // Fetch requester: level request held until its valid cycle.
      if (m_ifv) begin
        f_act = ($urandom_range(0, 1) == 1);
        if (f_act) if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_req = f_act;
      if_flush = ($urandom_range(0, 7) == 0);
      if (if_flush && f_act) if_addr = $urandom & 32'hFFFF_FFFC;

      // Data requester: command stable while the request is pending.
      if (m_dmv) begin
        d_act = ($urandom_range(0, 1) == 1);
        if (d_act) new_dm_cmd();
      end else if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1;
        new_dm_cmd();
      end
      dm_req = d_act;

      // Bus: random grant waits, 0-2 response waits, stray rvalid outside RESP.
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (m_busy && !m_gnt) begin
        mem_gnt    = ($urandom_range(0, 2) != 0);
        mem_rvalid = ($urandom_range(0, 5) == 0);
      end else if (m_busy) begin
        if (rv_wait == 0) mem_rvalid = 1;
        else rv_wait--;
      end else begin
        mem_rvalid = ($urandom_range(0, 5) == 0);
      end

      #1;
      check("if_stall", if_stall, if_req && !m_ifv && !if_flush);
      check("dm_stall", dm_stall, dm_req && !m_dmv);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
